circuito_gravador_memoria: RTL and testbench
============================================

// Module: circuito_gravador_memoria
// PURPOSE
// - Write-side counterpart of the switch-vs-memory comparison circuit: records a user-entered sequence of
//   4-bit switch values into a 16x4 RAM, one word per "jogada" button press, at consecutive addresses.
// - A RAM loaded here is the one the comparison circuit later reads. Internal: UC FSM, address counter,
//   data register, jogada edge detector, sync-write RAM, hexa7seg decoders for debug displays.
// PARAMETERS
// - ADDR_W  4   address/counter width; depth = 2**ADDR_W words
// - DATA_W  4   word width (= chaves width)
// PORTS
// - clock        in   1       system clock, all state on rising edge
// - reset        in   1       synchronous, active-high; returns FSM to INICIAL
// - iniciar      in   1       level; starts a recording session from INICIAL or FIM
// - jogada       in   1       button level; its 0->1 edge commits chaves to the current address
// - chaves       in   DATA_W  value to record
// - pronto       out  1       1 while in FIM (all 2**ADDR_W words written)
// - db_gravou    out  1       1 exactly during GRAVA (RAM write-enable)
// - db_jogada    out  1       raw jogada mirror
// - db_contagem  out  7       hexa7seg(current address)
// - db_memoria   out  7       hexa7seg(RAM[current address]), async read
// - db_dado      out  7       hexa7seg(data register)
// - db_estado    out  7       hexa7seg(state code)
// BEHAVIOUR
// - Reset: FSM=INICIAL, counter=0, data register=0, jogada_prev=0; pronto=0, db_gravou=0.
//   RAM contents are NOT reset. Reset mid-session aborts; already-written words persist.
// - Edge detect: jogada_prev <= jogada each cycle; pulso = jogada & ~jogada_prev (comb.).
//   Pulso is acted on only in ESPERA; edges elsewhere are ignored (not queued). Holding jogada gives one pulse.
// - States (db_estado code): INICIAL(0) PREPARA(1) ESPERA(2) REGISTRA(3) GRAVA(4) PROXIMO(5) FIM(F).
// - INICIAL: idle; iniciar=1 -> PREPARA, else stay.
// - PREPARA: zeraC, zeraR asserted (counter=0, register=0 at edge) -> ESPERA.
// - ESPERA: pulso=1 -> REGISTRA, else stay. iniciar ignored here.
// - REGISTRA: registraR; register <= chaves at the edge leaving this state -> GRAVA.
// - GRAVA: we=1, RAM[counter] <= register at the edge; fimC (counter==2**ADDR_W-1) -> FIM, else PROXIMO.
// - PROXIMO: contaC; counter+1 -> ESPERA. Counter never wraps in-session (FIM reached at last address).
// - FIM: pronto=1, counter held at 2**ADDR_W-1; iniciar=1 -> PREPARA (new session, overwrites from 0).
// - Latency: jogada high sampled at edge k (pulso in ESPERA) -> REGISTRA during k..k+1, chaves sampled at edge
//   k+1, RAM written at edge k+2, db_memoria shows new word during PROXIMO/FIM (cycle after k+2).
// - Simultaneous reset and iniciar/jogada: reset wins. chaves changes outside REGISTRA do not affect RAM.
// - Outputs pronto, db_gravou are Moore (decoded from state only); no glitch dependence on inputs.
// - Unused state encodings -> INICIAL on next edge.
// TESTING
// - Reset then idle 5 cycles -> db_estado code 0, pronto=0, db_gravou=0, counter=0.
// - iniciar pulse, then 16 jogada presses with chaves=0..F -> after each GRAVA db_memoria shows written value;
//   after 16th: pronto=1, state F, counter=F; exactly 16 db_gravou pulses total.
// - jogada held high 20 cycles in ESPERA with chaves=A -> exactly one write of A at address 0, counter=1.
// - chaves=3 at jogada edge, changed to 7 one cycle after REGISTRA -> RAM[addr]=3 (sampling point check).
// - Reset asserted during REGISTRA after 5 writes -> INICIAL, counter=0, RAM[0..4] retain written values.
// - From FIM, iniciar with chaves=C then one press -> pronto=0, RAM[0]=C, counter=1, state 2.

Source files
------------

// File: rtl/circuito_gravador_memoria_if.sv
// rtl/circuito_gravador_memoria_if.sv - user controls and debug outputs of the memory recorder
interface circuito_gravador_memoria_if #(
  parameter int DATA_W = 4
);
  logic              iniciar;
  logic              jogada;
  logic [DATA_W-1:0] chaves;
  logic              pronto;
  logic              db_gravou;
  logic              db_jogada;
  logic [6:0]        db_contagem;
  logic [6:0]        db_memoria;
  logic [6:0]        db_dado;
  logic [6:0]        db_estado;

  modport master (
    output iniciar, jogada, chaves,
    input  pronto, db_gravou, db_jogada, db_contagem, db_memoria, db_dado, db_estado
  );

  modport slave (
    input  iniciar, jogada, chaves,
    output pronto, db_gravou, db_jogada, db_contagem, db_memoria, db_dado, db_estado
  );
endinterface

// File: rtl/circuito_gravador_memoria.sv
// rtl/circuito_gravador_memoria.sv - records one switch word per jogada press into a 16x4 RAM
module circuito_gravador_memoria #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input logic                          clock,
  input logic                          reset,
  circuito_gravador_memoria_if.slave   bus
);
  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    ESPERA   = 4'h2,
    REGISTRA = 4'h3,
    GRAVA    = 4'h4,
    PROXIMO  = 4'h5,
    FIM      = 4'hF
  } estado_t;

  estado_t           estado, proximo;
  logic [ADDR_W-1:0] contagem;
  logic [DATA_W-1:0] dado;
  logic [DATA_W-1:0] memoria [2**ADDR_W];
  logic              jogada_prev;
  logic              pulso;
  logic              fim_c;
  logic              zera_c, zera_r, registra_r, conta_c, we;

  function automatic logic [6:0] hexa7seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign pulso = bus.jogada & ~jogada_prev;
  assign fim_c = (contagem == {ADDR_W{1'b1}});

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  // Encodings outside the enum fall to INICIAL through the default arm.
  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:  proximo = bus.iniciar ? PREPARA : INICIAL;
      PREPARA:  proximo = ESPERA;
      ESPERA:   proximo = pulso ? REGISTRA : ESPERA;
      REGISTRA: proximo = GRAVA;
      GRAVA:    proximo = fim_c ? FIM : PROXIMO;
      PROXIMO:  proximo = ESPERA;
      FIM:      proximo = bus.iniciar ? PREPARA : FIM;
      default:  proximo = INICIAL;
    endcase
  end

  always_comb begin
    zera_c     = 1'b0;
    zera_r     = 1'b0;
    registra_r = 1'b0;
    conta_c    = 1'b0;
    we         = 1'b0;
    bus.pronto = 1'b0;
    case (estado)
      PREPARA:  begin zera_c = 1'b1; zera_r = 1'b1; end
      REGISTRA: registra_r = 1'b1;
      GRAVA:    we = 1'b1;
      PROXIMO:  conta_c = 1'b1;
      FIM:      bus.pronto = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      contagem    <= '0;
      dado        <= '0;
      jogada_prev <= 1'b0;
    end else begin
      jogada_prev <= bus.jogada;
      if (zera_c)       contagem <= '0;
      else if (conta_c) contagem <= contagem + 1'b1;
      if (zera_r)          dado <= '0;
      else if (registra_r) dado <= bus.chaves;
    end
  end

  // RAM is deliberately outside the reset so a session abort keeps recorded words.
  always_ff @(posedge clock) begin
    if (we) memoria[contagem] <= dado;
  end

  assign bus.db_gravou   = we;
  assign bus.db_jogada   = bus.jogada;
  assign bus.db_contagem = hexa7seg(contagem);
  assign bus.db_memoria  = hexa7seg(memoria[contagem]);
  assign bus.db_dado     = hexa7seg(dado);
  assign bus.db_estado   = hexa7seg(estado);
endmodule

// File: tb/tb_circuito_gravador_memoria.sv
// tb/tb_circuito_gravador_memoria.sv - directed bench with a session-level model of the recorder
module tb_circuito_gravador_memoria;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   gravou_count = 0;

  circuito_gravador_memoria_if #(.DATA_W(4)) bus_if ();

  circuito_gravador_memoria #(.ADDR_W(4), .DATA_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  logic [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: phase of the session, address, held word, RAM image with written flags.
  int       m_st = 0;
  int       m_addr = 0;
  int       m_reg = 0;
  int       m_mem [16];
  bit       m_valid [16];
  bit       m_prev = 0;
  bit       model_ok = 0;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    bit pulso;
    pulso = bus_if.jogada && !m_prev;
    if (reset) begin
      m_st = 0; m_addr = 0; m_reg = 0; m_prev = 0; model_ok = 1;
    end else begin
      m_prev = bus_if.jogada;
      case (m_st)
        0:  if (bus_if.iniciar) m_st = 1;
        1:  begin m_addr = 0; m_reg = 0; m_st = 2; end
        2:  if (pulso) m_st = 3;
        3:  begin m_reg = int'(bus_if.chaves); m_st = 4; end
        4:  begin
              m_mem[m_addr] = m_reg; m_valid[m_addr] = 1;
              m_st = (m_addr == 15) ? 15 : 5;
            end
        5:  begin m_addr = m_addr + 1; m_st = 2; end
        15: if (bus_if.iniciar) m_st = 1;
        default: m_st = 0;
      endcase
    end
    #1;
    if (bus_if.db_gravou === 1'b1) gravou_count++;
    if (model_ok) begin
      chk("pronto", {6'b0, bus_if.pronto}, {6'b0, m_st == 15});
      chk("db_gravou", {6'b0, bus_if.db_gravou}, {6'b0, m_st == 4});
      chk("db_jogada", {6'b0, bus_if.db_jogada}, {6'b0, bus_if.jogada});
      chk("db_estado", bus_if.db_estado, seg[m_st]);
      chk("db_contagem", bus_if.db_contagem, seg[m_addr]);
      chk("db_dado", bus_if.db_dado, seg[m_reg]);
      if (m_valid[m_addr]) chk("db_memoria", bus_if.db_memoria, seg[m_mem[m_addr]]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_session();
    bus_if.iniciar = 1'b1;
    cyc(1);
    bus_if.iniciar = 1'b0;
    cyc(1);
  endtask

  task automatic press(input logic [3:0] v);
    bus_if.chaves = v;
    bus_if.jogada = 1'b1;
    cyc(2);
    bus_if.jogada = 1'b0;
    cyc(3);
  endtask

  initial begin
    int g0;
    bus_if.iniciar = 1'b0;
    bus_if.jogada  = 1'b0;
    bus_if.chaves  = 4'h0;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    chk("idle_estado", bus_if.db_estado, 7'b1000000);
    chk("idle_contagem", bus_if.db_contagem, 7'b1000000);
    chk("idle_pronto", {6'b0, bus_if.pronto}, 7'd0);
    chk("idle_gravou", {6'b0, bus_if.db_gravou}, 7'd0);

    // Full session 0..F
    start_session();
    g0 = gravou_count;
    for (int i = 0; i < 16; i++) press(4'(i));
    chk("full_pronto", {6'b0, bus_if.pronto}, 7'd1);
    chk("full_estado", bus_if.db_estado, 7'b0001110);
    chk("full_contagem", bus_if.db_contagem, 7'b0001110);
    chk("full_mem_last", bus_if.db_memoria, 7'b0001110);
    chk("full_writes", 7'(gravou_count - g0), 7'd16);

    // Held jogada gives one write
    reset = 1'b1; cyc(1); reset = 1'b0;
    start_session();
    g0 = gravou_count;
    bus_if.chaves = 4'hA;
    bus_if.jogada = 1'b1;
    cyc(20);
    bus_if.jogada = 1'b0;
    cyc(2);
    chk("hold_writes", 7'(gravou_count - g0), 7'd1);
    chk("hold_contagem", bus_if.db_contagem, 7'b1111001);
    chk("hold_estado", bus_if.db_estado, 7'b0100100);
    chk("hold_mem_addr1_old", bus_if.db_memoria, 7'b1111001);

    // chaves changes after the sampling edge do not reach RAM
    bus_if.chaves = 4'h3;
    bus_if.jogada = 1'b1;
    cyc(2);
    bus_if.chaves = 4'h7;
    bus_if.jogada = 1'b0;
    cyc(1);
    chk("sample_mem", bus_if.db_memoria, 7'b0110000);
    chk("sample_dado", bus_if.db_dado, 7'b0110000);
    cyc(2);

    // Reset during REGISTRA after five writes
    reset = 1'b1; cyc(1); reset = 1'b0;
    start_session();
    for (int i = 5; i < 10; i++) press(4'(i));
    bus_if.chaves = 4'hB;
    bus_if.jogada = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    bus_if.jogada = 1'b0;
    cyc(2);
    chk("abort_estado", bus_if.db_estado, 7'b1000000);
    chk("abort_contagem", bus_if.db_contagem, 7'b1000000);
    chk("abort_mem0", bus_if.db_memoria, 7'b0010010);
    chk("abort_dado", bus_if.db_dado, 7'b1000000);

    // Fill, then restart from FIM
    start_session();
    for (int i = 0; i < 16; i++) press(4'(15 - i));
    chk("fim_pronto", {6'b0, bus_if.pronto}, 7'd1);
    bus_if.chaves = 4'hC;
    start_session();
    press(4'hC);
    chk("restart_pronto", {6'b0, bus_if.pronto}, 7'd0);
    chk("restart_estado", bus_if.db_estado, 7'b0100100);
    chk("restart_contagem", bus_if.db_contagem, 7'b1111001);
    chk("restart_mem1_old", bus_if.db_memoria, 7'b0000110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
